conv_sequencer: RTL and testbench

//  Sequences the LeNet input-buffer/MAC datapath through SCONV_1, SCONV_2, SFC_1, SFC_2.

---
 rtl/conv_sequencer_pkg.sv | 25 ++
 rtl/conv_sequencer_win_counter.sv | 66 ++++++
 rtl/conv_sequencer.sv | 140 ++++++++++++++
 tb/tb_conv_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sequencer_pkg.sv
// Shared header for the LeNet conv/FC sequencer: layer codes, window slot map
// and a counter-width helper.
package conv_sequencer_pkg;

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] SCONV_1 = 4'd1;
  localparam logic [3:0] SCONV_2 = 4'd2;
  localparam logic [3:0] SFC_1   = 4'd3;
  localparam logic [3:0] SFC_2   = 4'd4;
  localparam logic [3:0] DONE    = 4'd5;

  localparam int MAC_NUM = 5;

  localparam int         SLOT_W      = 4;
  localparam logic [3:0] SLOT_LOAD   = 4'd0;
  localparam logic [3:0] SLOT_MAC_LO = 4'd1;
  localparam logic [3:0] SLOT_MAC_HI = 4'd5;
  localparam logic [3:0] SLOT_LAST   = 4'd9;

  // Width of a counter ranging over 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_sequencer_win_counter.sv
// Nested slot / ker_row / ich / tile counter. Terminal values arrive at run time
// so the same counter serves both conv windows and FC steps.
module win_counter #(
  parameter int SLOT_W = 4,
  parameter int ROW_W  = 3,
  parameter int ICH_W  = 3,
  parameter int TILE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              stall,
  input  logic [SLOT_W-1:0] slot_last,
  input  logic [ROW_W-1:0]  row_last,
  input  logic [ICH_W-1:0]  ich_last,
  input  logic [TILE_W-1:0] tile_last,
  output logic [SLOT_W-1:0] slot,
  output logic [ROW_W-1:0]  row,
  output logic [ICH_W-1:0]  ich,
  output logic [TILE_W-1:0] tile,
  output logic              all_end
);

  logic slot_end, row_end, ich_end, tile_end, adv;

  assign slot_end = (slot == slot_last);
  assign row_end  = (row == row_last);
  assign ich_end  = (ich == ich_last);
  assign tile_end = (tile == tile_last);
  assign all_end  = slot_end & row_end & ich_end & tile_end;
  // Saturates at the final position; the owner clears it before the next layer.
  assign adv      = en & ~stall & ~all_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot <= '0;
      row  <= '0;
      ich  <= '0;
      tile <= '0;
    end else if (clr) begin
      slot <= '0;
      row  <= '0;
      ich  <= '0;
      tile <= '0;
    end else if (adv) begin
      if (!slot_end) begin
        slot <= slot + 1'b1;
      end else begin
        slot <= '0;
        if (!row_end) begin
          row <= row + 1'b1;
        end else begin
          row <= '0;
          if (!ich_end) begin
            ich <= ich + 1'b1;
          end else begin
            ich  <= '0;
            tile <= tile + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// Walks the input-buffer/MAC datapath through SCONV_1, SCONV_2, SFC_1, SFC_2,
// keeping the buffer's 10-slot load counter aligned and qualifying the MACs.
module conv_sequencer
  import conv_sequencer_pkg::*;
#(
  parameter int C1_TILES  = 7,
  parameter int C1_ICH    = 1,
  parameter int C2_TILES  = 1,
  parameter int C2_ICH    = 6,
  parameter int FC1_STEPS = 5,
  parameter int FC2_STEPS = 2,
  parameter int KER       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       src_valid,
  output logic       src_ready,
  output logic       buf_en,
  output logic [3:0] cur_state,
  output logic [3:0] ker_row,
  output logic [3:0] ker_col,
  output logic       mac_valid,
  output logic       acc_clr,
  output logic       tile_done,
  output logic       busy,
  output logic       done
);

  localparam int ROW_W  = cnt_w(KER);
  localparam int ICH_W  = cnt_w((C1_ICH > C2_ICH) ? C1_ICH : C2_ICH);
  localparam int T_CONV = (C1_TILES > C2_TILES) ? C1_TILES : C2_TILES;
  localparam int T_FC   = (FC1_STEPS > FC2_STEPS) ? FC1_STEPS : FC2_STEPS;
  localparam int TILE_W = cnt_w((T_CONV > T_FC) ? T_CONV : T_FC);

  logic [3:0]        state;
  logic              tail;
  logic [SLOT_W-1:0] slot, slot_last;
  logic [ROW_W-1:0]  row, row_last;
  logic [ICH_W-1:0]  ich, ich_last;
  logic [TILE_W-1:0] tile, tile_last;
  logic              all_end, layer, conv, work, load, stall, conv_mac, fc_mac;

  assign layer = (state == SCONV_1) || (state == SCONV_2) || (state == SFC_1) || (state == SFC_2);
  assign conv  = (state == SCONV_1) || (state == SCONV_2);
  // Every layer finishes with one tail cycle; it separates the layers and carries FC tile_done.
  assign work  = layer & ~tail;
  assign load  = work & (slot == SLOT_LOAD);
  assign stall = load & ~src_valid;

  always_comb begin
    slot_last = '0;
    row_last  = '0;
    ich_last  = '0;
    tile_last = '0;
    case (state)
      SCONV_1: begin
        slot_last = SLOT_LAST;
        row_last  = ROW_W'(KER - 1);
        ich_last  = ICH_W'(C1_ICH - 1);
        tile_last = TILE_W'(C1_TILES - 1);
      end
      SCONV_2: begin
        slot_last = SLOT_LAST;
        row_last  = ROW_W'(KER - 1);
        ich_last  = ICH_W'(C2_ICH - 1);
        tile_last = TILE_W'(C2_TILES - 1);
      end
      SFC_1: begin
        slot_last = SLOT_MAC_LO;
        tile_last = TILE_W'(FC1_STEPS - 1);
      end
      SFC_2: begin
        slot_last = SLOT_MAC_LO;
        tile_last = TILE_W'(FC2_STEPS - 1);
      end
      default: ;
    endcase
  end

  win_counter #(
    .SLOT_W(SLOT_W),
    .ROW_W (ROW_W),
    .ICH_W (ICH_W),
    .TILE_W(TILE_W)
  ) u_win (
    .clk      (clk),
    .rst      (rst),
    .clr      (~work),
    .en       (work),
    .stall    (stall),
    .slot_last(slot_last),
    .row_last (row_last),
    .ich_last (ich_last),
    .tile_last(tile_last),
    .slot     (slot),
    .row      (row),
    .ich      (ich),
    .tile     (tile),
    .all_end  (all_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      tail  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) state <= SCONV_1;
        SCONV_1, SCONV_2, SFC_1, SFC_2: begin
          if (tail) begin
            tail  <= 1'b0;
            state <= state + 4'd1;
          end else if (!stall && all_end) begin
            tail <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Only buf_en/src_ready see src_valid; MAC qualifiers decode from flops alone.
  assign conv_mac  = work & conv & (slot >= SLOT_MAC_LO) & (slot <= SLOT_MAC_HI);
  assign fc_mac    = work & ~conv & (slot == SLOT_MAC_LO);
  assign buf_en    = load ? src_valid : (work & conv);
  assign src_ready = load & src_valid;
  assign mac_valid = conv_mac | fc_mac;
  assign ker_col   = conv_mac ? (slot - SLOT_MAC_LO) : 4'd0;
  assign ker_row   = conv_mac ? 4'(row) : 4'd0;
  assign acc_clr   = (conv_mac & (slot == SLOT_MAC_LO) & (row == '0) & (ich == '0)) |
                     (fc_mac & (tile == '0));
  assign tile_done = (work & conv & (slot == (SLOT_MAC_HI + 4'd1)) & (row == row_last) &
                      (ich == ich_last)) | (layer & ~conv & tail);
  assign cur_state = layer ? state : IDLE;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: an expanded per-cycle schedule of the whole network
// is compared against the DUT every cycle, plus hand-computed counts.
module tb_conv_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, src_valid;
  logic       src_ready, buf_en, mac_valid, acc_clr, tile_done, busy, done;
  logic [3:0] cur_state, ker_row, ker_col;

  conv_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .buf_en   (buf_en),
    .cur_state(cur_state),
    .ker_row  (ker_row),
    .ker_col  (ker_col),
    .mac_valid(mac_valid),
    .acc_clr  (acc_clr),
    .tile_done(tile_done),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ld;
    logic [3:0] cs;
    logic [3:0] kr;
    logic [3:0] kc;
    logic       be, mv, ac, td, bz, dn;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_fail = 0;
  int   run_cyc, done_cnt, total, sc2_mv, sc2_ac, sc2_td, buf_cnt;
  bit   running, lit_mode, seen_mac;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      if (n_fail <= 60) $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic exp_t blank(input logic [3:0] cs);
    exp_t e = '0;
    e.cs = cs;
    e.bz = 1'b1;
    return e;
  endfunction

  task automatic push_conv(input logic [3:0] cs, input int tiles, input int ichs);
    exp_t e;
    for (int t = 0; t < tiles; t++)
      for (int c = 0; c < ichs; c++)
        for (int r = 0; r < 5; r++)
          for (int s = 0; s < 10; s++) begin
            e = blank(cs);
            e.ld = (s == 0);
            e.be = 1'b1;
            if (s >= 1 && s <= 5) begin
              e.mv = 1'b1;
              e.kr = 4'(r);
              e.kc = 4'(s - 1);
              e.ac = (s == 1 && r == 0 && c == 0);
            end
            e.td = (s == 6 && r == 4 && c == ichs - 1);
            q.push_back(e);
          end
    q.push_back(blank(cs));
  endtask

  task automatic push_fc(input logic [3:0] cs, input int steps);
    exp_t e;
    for (int k = 0; k < steps; k++) begin
      e = blank(cs);
      e.ld = 1'b1;
      q.push_back(e);
      e = blank(cs);
      e.mv = 1'b1;
      e.ac = (k == 0);
      q.push_back(e);
    end
    e = blank(cs);
    e.td = 1'b1;
    q.push_back(e);
  endtask

  task automatic push_network();
    exp_t e = '0;
    push_conv(4'd1, 7, 1);
    push_conv(4'd2, 1, 6);
    push_fc(4'd3, 5);
    push_fc(4'd4, 2);
    e.bz = 1'b1;
    e.dn = 1'b1;
    q.push_back(e);
  endtask

  task automatic tick(input logic sv, input logic st);
    exp_t        h;
    logic [18:0] got, want;
    logic        acc;
    @(negedge clk);
    src_valid = sv;
    start     = st;
    #1;
    acc  = st && rst && (q.size() == 0);
    got  = {cur_state, ker_row, ker_col, buf_en, src_ready, mac_valid, acc_clr, tile_done, busy, done};
    want = '0;
    if (q.size() > 0) begin
      h    = q[0];
      want = {h.cs, h.kr, h.kc, (h.ld ? sv : h.be), (h.ld & sv), h.mv, h.ac, h.td, h.bz, h.dn};
    end
    check("outputs", 32'(got), 32'(want));

    if ((cur_state == 4'd1 || cur_state == 4'd2) && src_ready) check("buf_align", buf_cnt, 0);
    if (cur_state == 4'd1 || cur_state == 4'd2) begin
      if (buf_en) buf_cnt = (buf_cnt + 1) % 10;
    end else begin
      buf_cnt = 0;
    end

    if (running) begin
      run_cyc++;
      if (lit_mode && run_cyc >= 1 && run_cyc <= 10) begin
        check("t1_buf_en", buf_en, 1);
        check("t1_acc_clr", acc_clr, (run_cyc == 2));
        if (run_cyc >= 2 && run_cyc <= 6) check("t1_ker_col", ker_col, run_cyc - 2);
      end
      if (mac_valid && !seen_mac) begin
        seen_mac = 1'b1;
        check("first_mac_row", ker_row, 0);
        check("first_mac_state", cur_state, 1);
      end
      if (cur_state == 4'd2) begin
        sc2_mv += int'(mac_valid);
        sc2_ac += int'(acc_clr);
        sc2_td += int'(tile_done);
      end
      if (done) begin
        done_cnt++;
        total = run_cyc + 1;
      end
    end

    if (q.size() > 0 && (!h.ld || sv)) void'(q.pop_front());
    if (acc) begin
      running  = 1'b1;
      seen_mac = 1'b0;
      run_cyc  = 0;
      done_cnt = 0;
      total    = 0;
      sc2_mv   = 0;
      sc2_ac   = 0;
      sc2_td   = 0;
      buf_cnt  = 0;
      push_network();
    end
  endtask

  task automatic run_to_done(input int p_valid, input int guard, input bit pulse);
    int n = 0;
    while (done_cnt == 0 && n < guard) begin
      tick($urandom_range(99) < p_valid, pulse && (n % 150 == 75));
      n++;
    end
    if (done_cnt == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL run_timeout: got no done after %0d cycles, expected one", guard);
    end
  endtask

  initial begin
    logic [18:0] vec;
    int          n, drops;
    logic        sv;
    rst = 1'b1; start = 1'b0; src_valid = 1'b0;
    running = 1'b0; lit_mode = 1'b0; seen_mac = 1'b0;
    run_cyc = 0; done_cnt = 0; total = 0; buf_cnt = 0;
    sc2_mv = 0; sc2_ac = 0; sc2_td = 0;
    #2 rst = 1'b0;

    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    check("reset_busy", busy, 0);
    check("reset_state", cur_state, 0);
    rst = 1'b1;

    // Full run with src_valid held high; start re-pulsed while busy.
    lit_mode = 1'b1;
    tick(1'b1, 1'b1);
    run_to_done(100, 2000, 1'b1);
    lit_mode = 1'b0;
    check("total_cycles", total, 670);
    check("sc2_mac_valid", sc2_mv, 150);
    check("sc2_acc_clr", sc2_ac, 1);
    check("sc2_tile_done", sc2_td, 1);
    repeat (4) tick(1'b1, 1'b0);
    check("busy_after", busy, 0);
    check("done_count", done_cnt, 1);

    // Random stalls, a forced 3-cycle stall, then reset inside SCONV_2 ker_row 3.
    tick(1'b1, 1'b1);
    n = 0;
    drops = 3;
    while (!(q.size() > 0 && q[0].cs == 4'd2 && q[0].mv && q[0].kr == 4'd3) && n < 3000) begin
      sv = ($urandom_range(99) < 70);
      if (drops > 0 && n > 15 && q.size() > 0 && q[0].ld) begin
        sv = 1'b0;
        drops--;
        tick(sv, 1'b0);
        check("stall_buf_en", buf_en, 0);
      end else begin
        tick(sv, 1'b0);
      end
      n++;
    end
    tick(1'b1, 1'b0);
    check("pre_rst_row", ker_row, 3);
    rst = 1'b0;
    #1;
    vec = {cur_state, ker_row, ker_col, buf_en, src_ready, mac_valid, acc_clr, tile_done, busy, done};
    check("rst_zero", 32'(vec), 0);
    q.delete();
    running = 1'b0;
    buf_cnt = 0;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    rst = 1'b1;

    // Restart after the mid-layer reset with random source stalls.
    tick(1'b1, 1'b1);
    run_to_done(70, 4000, 1'b1);
    repeat (3) tick(1'b1, 1'b0);
    check("done_count_2", done_cnt, 1);
    check("busy_after_2", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
